// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch stage.
// FETCH_PERF_EN (optional) enables the delivered-instruction counter in fetch_stage.
package fetch_pkg;

  localparam int N      = 64;
  localparam int ROM_AW = 6;

  localparam logic [31:0]  NOP_INSTR = 32'h00000000;
  localparam logic [N-1:0] PC_INC    = 64'd4;
  localparam logic [N-1:0] WORD_MASK = ~64'd3;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [N-1:0] pc;
    logic [31:0]  instr;
    logic         valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{pc: 64'd0, instr: NOP_INSTR, valid: 1'b0};

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    if (v == 32'hFFFFFFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Control, ROM and IF/ID signal bundle between the fetch stage and its surroundings.
// slave = fetch_stage side, master = core/testbench side.
interface fetch_stage_if;
  import fetch_pkg::*;

  logic                stall_i;
  logic                flush_i;
  logic                pcsrc_i;
  logic [N-1:0]        branch_target_i;
  logic                halt_i;
  logic [ROM_AW-1:0]   imem_addr_o;
  logic [31:0]         imem_q_i;
  logic [N-1:0]        pc_id_o;
  logic [31:0]         instr_id_o;
  logic                valid_id_o;
  logic                halted_o;
  logic [31:0]         fetch_cnt_o;

  modport slave (
    input  stall_i, flush_i, pcsrc_i, branch_target_i, halt_i, imem_q_i,
    output imem_addr_o, pc_id_o, instr_id_o, valid_id_o, halted_o, fetch_cnt_o
  );

  modport master (
    output stall_i, flush_i, pcsrc_i, branch_target_i, halt_i, imem_q_i,
    input  imem_addr_o, pc_id_o, instr_id_o, valid_id_o, halted_o, fetch_cnt_o
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: bubble beats hold beats load; idle cycles keep contents.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_load,
  input  logic   i_hold,
  input  logic   i_bubble,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  // IF/ID storage with synchronous active-low reset to a bubble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= IF_ID_BUBBLE;
    end else if (i_bubble) begin
      r_q <= IF_ID_BUBBLE;
    end else if (i_hold) begin
      r_q <= r_q;
    end else if (i_load) begin
      r_q <= i_d;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 fetch stage: PC, next-PC selection, BOOT/RUN/HALT control and IF/ID capture.
// Define FETCH_PERF_EN to build the saturating delivered-instruction counter.
module fetch_stage
  import fetch_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.slave  bus
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [N-1:0] r_pc;
  logic [N-1:0] w_pc_nxt;
  logic [N-1:0] w_target;
  logic         w_load;
  logic         w_hold;
  logic         w_bubble;
  if_id_t       w_ifid_d;
  if_id_t       w_ifid_q;

  assign w_target = bus.branch_target_i & WORD_MASK;
  assign w_ifid_d = '{pc: r_pc, instr: bus.imem_q_i, valid: 1'b1};

  // Next state, next PC and IF/ID control; redirect has top priority, even over stall
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_load      = 1'b0;
    w_hold      = 1'b0;
    w_bubble    = 1'b0;
    case (r_state)
      BOOT: begin
        w_state_nxt = RUN;
        w_pc_nxt    = 64'd0;
        w_bubble    = 1'b1;
      end
      RUN: begin
        if (bus.pcsrc_i) begin
          w_pc_nxt = w_target;
          w_bubble = 1'b1;
        end else if (bus.flush_i) begin
          w_bubble = 1'b1;
          if (!bus.stall_i) begin
            w_pc_nxt = r_pc + PC_INC;
          end else begin
            w_pc_nxt = r_pc;
          end
        end else if (bus.stall_i) begin
          w_hold = 1'b1;
        end else if (bus.halt_i) begin
          w_state_nxt = HALT;
          w_bubble    = 1'b1;
        end else begin
          w_load   = 1'b1;
          w_pc_nxt = r_pc + PC_INC;
        end
      end
      HALT: begin
        w_bubble = 1'b1;
        if (bus.pcsrc_i) begin
          w_state_nxt = RUN;
          w_pc_nxt    = w_target;
        end else begin
          w_state_nxt = HALT;
        end
      end
      default: begin
        w_state_nxt = BOOT;
        w_pc_nxt    = 64'd0;
        w_bubble    = 1'b1;
      end
    endcase
  end

  // State and PC registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= BOOT;
      r_pc    <= 64'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst_n    (reset),
    .i_load   (w_load),
    .i_hold   (w_hold),
    .i_bubble (w_bubble),
    .i_d      (w_ifid_d),
    .o_q      (w_ifid_q)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_cnt;

  // Count every edge that loads a real instruction into IF/ID
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetch_cnt <= 32'd0;
    end else if (w_load) begin
      r_fetch_cnt <= sat_inc32(r_fetch_cnt);
    end else begin
      r_fetch_cnt <= r_fetch_cnt;
    end
  end

  assign bus.fetch_cnt_o = r_fetch_cnt;
`else
  assign bus.fetch_cnt_o = 32'd0;
`endif

  assign bus.imem_addr_o = r_pc[ROM_AW+1:2];
  assign bus.pc_id_o     = w_ifid_q.pc;
  assign bus.instr_id_o  = w_ifid_q.instr;
  assign bus.valid_id_o  = w_ifid_q.valid;
  assign bus.halted_o    = (r_state == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a cycle-level reference model predicts the
// post-edge outputs; a separate monitor compares them one time unit after each edge.
module tb_fetch_stage;

  typedef struct {
    logic [5:0]  addr;
    logic [63:0] pc_id;
    logic [31:0] instr;
    logic        valid;
    logic        halted;
    logic [31:0] cnt;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] rom [64];
  exp_t        sb [$];
  int          vectors;
  int          miscompares;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.imem_q_i = rom[bus.imem_addr_o];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, expressed in the architectural terms of the stage
  logic [63:0] m_pc;
  bit          m_boot;
  bit          m_halted;
  logic [63:0] m_id_pc;
  logic [31:0] m_id_instr;
  logic        m_id_valid;
  logic [31:0] m_cnt;

  task automatic bubble();
    m_id_pc    = 64'd0;
    m_id_instr = 32'h00000000;
    m_id_valid = 1'b0;
  endtask

  // One clock: drive inputs at the falling edge, predict the post-edge outputs.
  task automatic step(input bit rst_n, input bit st, input bit fl, input bit br,
                      input logic [63:0] tgt, input bit hl);
    exp_t e;
    @(negedge clk);
    reset               = rst_n;
    bus.stall_i         = st;
    bus.flush_i         = fl;
    bus.pcsrc_i         = br;
    bus.branch_target_i = tgt;
    bus.halt_i          = hl;
    if (!rst_n) begin
      m_boot = 1; m_halted = 0; m_pc = 64'd0; m_cnt = 32'd0; bubble();
    end else if (m_boot) begin
      m_boot = 0; m_pc = 64'd0; bubble();
    end else if (m_halted) begin
      bubble();
      if (br) begin
        m_halted = 0;
        m_pc = (tgt / 64'd4) * 64'd4;
      end
    end else if (br) begin
      bubble();
      m_pc = (tgt / 64'd4) * 64'd4;
    end else if (fl) begin
      bubble();
      if (!st) m_pc = m_pc + 64'd4;
    end else if (st) begin
      // everything holds
    end else if (hl) begin
      m_halted = 1;
      bubble();
    end else begin
      m_id_pc    = m_pc;
      m_id_instr = rom[(m_pc / 64'd4) % 64];
      m_id_valid = 1'b1;
      m_pc       = m_pc + 64'd4;
`ifdef FETCH_PERF_EN
      if (m_cnt != 32'hFFFFFFFF) m_cnt = m_cnt + 32'd1;
`endif
    end
    e.addr   = 6'((m_pc / 64'd4) % 64);
    e.pc_id  = m_id_pc;
    e.instr  = m_id_instr;
    e.valid  = m_id_valid;
    e.halted = m_halted;
    e.cnt    = m_cnt;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 64'd0, 0);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, req);
    end
  endtask

  // Monitor: every edge presents a new IF/ID state; pop the prediction and compare
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("imem_addr_o", 64'(bus.imem_addr_o), 64'(e.addr));
        chk("pc_id_o",     bus.pc_id_o,          e.pc_id);
        chk("instr_id_o",  64'(bus.instr_id_o),  64'(e.instr));
        chk("valid_id_o",  64'(bus.valid_id_o),  64'(e.valid));
        chk("halted_o",    64'(bus.halted_o),    64'(e.halted));
        chk("fetch_cnt_o", 64'(bus.fetch_cnt_o), 64'(e.cnt));
      end
    end
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.pcsrc_i = 1'b0;
    bus.branch_target_i = 64'd0;
    bus.halt_i = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[0] = 32'h91003fe1;

    // Reset, then free-run across the word-63 -> word-0 wrap
    step(0, 0, 0, 0, 64'd0, 0);
    step(0, 0, 0, 0, 64'd0, 0);
    idle(67);

    // Restart, reach PC 8, stall three cycles, resume
    step(0, 0, 0, 0, 64'd0, 0);
    idle(3);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 64'd0, 0);
    idle(2);

    // Redirect to unaligned 0x2E while stalled
    step(1, 1, 0, 1, 64'h2E, 0);
    idle(2);

    // Redirect to 16, halt there, sit in HALT, leave via redirect to 0
    step(1, 0, 0, 1, 64'd16, 0);
    step(1, 0, 0, 0, 64'd0, 1);
    step(1, 0, 0, 0, 64'd0, 1);
    idle(3);
    step(1, 0, 0, 1, 64'd0, 0);
    idle(3);

    // Redirect and halt together, flush with and without stall
    step(1, 0, 0, 1, 64'd40, 1);
    idle(1);
    step(1, 0, 1, 0, 64'd0, 0);
    step(1, 1, 1, 0, 64'd0, 0);
    idle(2);

    // Randomized traffic with occasional mid-run reset
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) == 0),
           {$urandom, $urandom},
           ($urandom_range(0, 15) == 0));
    end

    @(posedge clk);
    #2;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: actual=%0d pending required=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage pipelined LEGv8 core. It owns the program counter, drives the word address of the 64-entry instruction ROM, and captures the returned instruction into the IF/ID pipeline register consumed by decode. It supports stall, flush, branch redirect and a halt state.

## Interface
- N, 64, datapath/PC width
- AW, 6, instruction ROM word-address width (64 words)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- stall_i  in  1  hazard unit: hold PC and IF/ID
- flush_i  in  1  squash IF/ID contents to bubble
- pcsrc_i  in  1  branch taken, load branch_target_i
- branch_target_i  in  N  byte address of branch target
- halt_i  in  1  request fetch halt
- imem_addr_o  out  AW  ROM word address = pc[AW+1:2]
- imem_q_i  in  32  ROM read data, combinational in imem_addr_o
- pc_id_o  out  N  PC of instruction in IF/ID
- instr_id_o  out  32  instruction in IF/ID
- valid_id_o  out  1  IF/ID holds a real instruction
- halted_o  out  1  fetch is in HALT
- fetch_cnt_o  out  32  instructions delivered (see Configuration)

## Operation
- States: BOOT, RUN, HALT.
- BOOT: entered on reset; lasts exactly one cycle, then RUN. PC = 0; IF/ID loaded with bubble.
- Bubble = instr 32'h00000000 (NOP), valid 0, pc_id 0.
- RUN, per cycle, priority highest first:
  - pcsrc_i: PC <= {branch_target_i[N-1:2], 2'b00}; IF/ID <= bubble. Applies even when stall_i = 1.
  - flush_i (no pcsrc_i): IF/ID <= bubble; PC advances by 4 unless stall_i.
  - stall_i: PC and IF/ID hold.
  - halt_i: go to HALT; PC holds; IF/ID <= bubble.
  - else: IF/ID <= {pc, imem_q_i, valid 1}; PC <= PC + 4.
- PC + 4 wraps modulo 2^N; imem_addr_o uses only PC[AW+1:2], so word 63 wraps to word 0.
- HALT: PC holds; IF/ID bubble each cycle; halted_o = 1. Exits only to RUN via pcsrc_i, with redirect applied that cycle, or via reset. halt_i ignored in HALT.
- Simultaneous pcsrc_i and halt_i in RUN: redirect wins; stay in RUN.
- Reset mid-operation overrides everything: next state BOOT, all outputs at reset values.

## Timing
- Reset values: PC 0, imem_addr_o 0, pc_id_o 0, instr_id_o 0, valid_id_o 0, halted_o 0, fetch_cnt_o 0.
- imem_addr_o is combinational from the PC register. The ROM is asynchronous read, so imem_q_i is sampled at the same edge that advances PC.
- Fetch latency: an instruction at PC appears on instr_id_o one cycle after PC holds it.
- Redirect penalty: the first target instruction appears in IF/ID two edges after the pcsrc_i edge. There is one bubble cycle in IF/ID.
- After reset deassertion: first edge is BOOT, so word 0 appears on instr_id_o after the second edge.
- halted_o rises the edge after halt_i is sampled in RUN.

## Configuration
- FETCH_PERF_EN defined:
  - fetch_cnt_o increments by 1 on every edge that loads valid 1 into IF/ID.
  - It saturates at 32'hFFFFFFFF.
  - It clears on reset.
- FETCH_PERF_EN undefined: fetch_cnt_o tied to 0; no counter logic.

## Structure
- Package fetch_pkg holds:
  - NOP_INSTR = 32'h00000000
  - fetch_state_t enum {BOOT, RUN, HALT}
  - if_id_t packed struct {pc, instr, valid}
  - ROM_AW = 6
- Sub-module if_id_reg holds the IF/ID register. Its controls are load, hold, bubble, and it has a synchronous active-low reset. fetch_stage instantiates it.
- PC register, next-PC mux, FSM and optional counter live in fetch_stage.

## Test plan
- Reset low 2 cycles, release, ROM word0 = 32'h91003fe1:
  - edge 1 after release: valid_id_o = 0
  - edge 2 after release: instr_id_o = 32'h91003fe1, pc_id_o = 0, valid 1, imem_addr_o = 1
- Free run 66 edges from word 0: imem_addr_o wraps 63 -> 0; pc_id_o of word 63 = 252; PC = 256 then 260.
- stall_i held 3 cycles at PC = 8: imem_addr_o stays 2; instr_id_o and pc_id_o unchanged; resumes at PC 12.
- pcsrc_i with target 0x2E, concurrent with stall_i:
  - PC = 0x2C, imem_addr_o = 11
  - next cycle IF/ID = bubble
  - following cycle pc_id_o = 0x2C, valid 1
- halt_i at PC = 16: halted_o = 1 next edge; bubbles continue; pcsrc_i to 0 exits; word 0 reaches IF/ID two edges later.
- FETCH_PERF_EN, 10 normal fetches, 1 flush, 2 stalls: fetch_cnt_o = 10; without macro fetch_cnt_o = 0.
